// File: rtl/wma_fir_pkg.sv
// wma_fir_filter shared constants and helpers.
// Binomial {1,3,3,1} taps, divide-by-8 normalisation.
package wma_fir_pkg;

  localparam int TAPS        = 4;
  localparam int COEFF[TAPS] = '{1, 3, 3, 1};
  localparam int NORM_SHIFT  = 3;
  localparam int ROUND_CONST = 4;

  function automatic int acc_width(input int n);
    return n + 3;
  endfunction

endpackage

// File: rtl/wma_fir_if.sv
// Streaming sample bus for wma_fir_filter.
// Master drives samples in, slave returns filtered samples.
interface wma_fir_if #(
  parameter int N = 8
);

  logic [N-1:0] data_in;
  logic [N-1:0] data_out;

  modport master (
    output data_in,
    input  data_out
  );

  modport slave (
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/wma_fir_delay_line.sv
// Sample history for wma_fir_filter.
// Tap 0 (newest) sits in the low N bits of taps.
module wma_fir_delay_line
  import wma_fir_pkg::*;
#(
  parameter int N    = 8,
  parameter int TAPS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    din,
  output logic [TAPS*N-1:0] taps
);

  logic [TAPS*N-1:0] line_q;
  logic [TAPS*N-1:0] line_d;

  // shift every tap one place older, newest sample enters at tap 0
  always_comb begin
    line_d = {line_q[(TAPS-1)*N-1:0], din};
  end

  // history register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign taps = line_q;

endmodule

// File: rtl/wma_fir_filter.sv
// 4-tap {1,3,3,1}/8 moving-average filter, one sample per clock.
// Define WMA_FIR_ROUND_EN for round-half-up instead of truncation.
module wma_fir_filter
  import wma_fir_pkg::*;
#(
  parameter int N = 8
) (
  input  logic      clk,
  input  logic      reset,
  wma_fir_if.slave  bus
);

  localparam int AW = acc_width(N);

  logic [TAPS*N-1:0] taps;
  logic [AW-1:0]     tap;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_r;
  logic [N-1:0]      data_out_d;
  logic [N-1:0]      data_out_q;

  wma_fir_delay_line #(
    .N    (N),
    .TAPS (TAPS)
  ) u_dl (
    .clk   (clk),
    .reset (reset),
    .din   (bus.data_in),
    .taps  (taps)
  );

  // weighted sum of the pre-edge history; 3x done as (x<<1)+x
  always_comb begin
    acc = '0;
    tap = '0;
    for (int i = 0; i < TAPS; i++) begin
      tap = AW'(taps[i*N +: N]);
      if (COEFF[i] == 3) begin
        acc = acc + (tap << 1) + tap;
      end else begin
        acc = acc + tap;
      end
    end
  end

  // normalise; accumulator headroom keeps the result within N bits
  always_comb begin
`ifdef WMA_FIR_ROUND_EN
    acc_r = acc + AW'(ROUND_CONST);
`else
    acc_r = acc;
`endif
    data_out_d = acc_r[NORM_SHIFT +: N];
  end

  // output register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_wma_fir_filter.sv
// Directed self-checking bench for wma_fir_filter.
// Expected values hand-derived from the {1,3,3,1}/8 equation.
module tb_wma_fir_filter;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  wma_fir_if #(.N(8)) bus ();

  wma_fir_filter #(.N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WMA_FIR_ROUND_EN
  localparam logic [7:0] I4_1 = 8'h01;
  localparam logic [7:0] I4_2 = 8'h02;
  localparam logic [7:0] I4_3 = 8'h02;
  localparam logic [7:0] I4_4 = 8'h01;
  localparam logic [7:0] FS_1 = 8'h20;
  localparam logic [7:0] FS_2 = 8'h80;
  localparam logic [7:0] R_55 = 8'h0B;
`else
  localparam logic [7:0] I4_1 = 8'h00;
  localparam logic [7:0] I4_2 = 8'h01;
  localparam logic [7:0] I4_3 = 8'h01;
  localparam logic [7:0] I4_4 = 8'h00;
  localparam logic [7:0] FS_1 = 8'h1F;
  localparam logic [7:0] FS_2 = 8'h7F;
  localparam logic [7:0] R_55 = 8'h0A;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [7:0] din);
    bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag,
                      input logic [7:0] din,
                      input logic [7:0] exp);
    tick(din);
    chk(tag, 32'(bus.data_out), 32'(exp));
  endtask

  task automatic do_reset();
    bus.data_in = 8'h00;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.data_in = 8'h00;
    reset       = 1'b1;
    #2;
    chk("por_out", 32'(bus.data_out), 32'h0);
    chk("por_taps", dut.taps, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    tick(8'hFF);
    tick(8'hFF);
    tick(8'hFF);
    tick(8'hFF);
    tick(8'($urandom_range(1, 255)));
    tick(8'($urandom_range(1, 255)));
    reset = 1'b1;
    #2;
    chk("rst_async_out", 32'(bus.data_out), 32'h0);
    chk("rst_async_taps", dut.taps, 32'h0);
    bus.data_in = 8'hAA;
    @(posedge clk);
    #1;
    chk("rst_hold_out", 32'(bus.data_out), 32'h0);
    chk("rst_hold_taps", dut.taps, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step("rst_first", 8'h55, 8'h00);
    step("rst_second", 8'h00, R_55);

    do_reset();
    step("step_e1", 8'h80, 8'h00);
    step("step_e2", 8'h80, 8'h10);
    step("step_e3", 8'h80, 8'h40);
    step("step_e4", 8'h80, 8'h70);
    step("step_e5", 8'h80, 8'h80);
    step("step_e6", 8'h80, 8'h80);

    do_reset();
    step("imp8_e1", 8'h08, 8'h00);
    step("imp8_e2", 8'h00, 8'h01);
    step("imp8_e3", 8'h00, 8'h03);
    step("imp8_e4", 8'h00, 8'h03);
    step("imp8_e5", 8'h00, 8'h01);
    step("imp8_e6", 8'h00, 8'h00);

    do_reset();
    step("imp4_e1", 8'h04, 8'h00);
    step("imp4_e2", 8'h00, I4_1);
    step("imp4_e3", 8'h00, I4_2);
    step("imp4_e4", 8'h00, I4_3);
    step("imp4_e5", 8'h00, I4_4);
    step("imp4_e6", 8'h00, 8'h00);

    do_reset();
    step("fs_e1", 8'hFF, 8'h00);
    step("fs_e2", 8'hFF, FS_1);
    step("fs_e3", 8'hFF, FS_2);
    step("fs_e4", 8'hFF, 8'hDF);
    step("fs_e5", 8'hFF, 8'hFF);
    step("fs_e6", 8'hFF, 8'hFF);
    step("fs_e7", 8'hFF, 8'hFF);

    do_reset();
    tick(8'h00);
    tick(8'h10);
    tick(8'h00);
    tick(8'h10);
    step("alt_e5", 8'h00, 8'h08);
    step("alt_e6", 8'h10, 8'h08);
    step("alt_e7", 8'h00, 8'h08);
    step("alt_e8", 8'h10, 8'h08);
    step("alt_e9", 8'h00, 8'h08);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
